// File: rtl/dbus_wb_bridge.sv
// Bridge from the MEM-stage data-RAM port to a Wishbone B4 classic master.
// Define DBUS_WB_TIMEOUT_EN to add a bus-wait watchdog and the bus_err_o output.
module dbus_wb_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  input  logic                cpu_stall_i,
  input  logic                flush_i,
  output logic [DATA_W-1:0]   cpu_rdata_o,
  output logic                stallreq_o,
`ifdef DBUS_WB_TIMEOUT_EN
  output logic                bus_err_o,
`endif
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   rd_hold;
  logic                bus_done;
  logic [DATA_W-1:0]   hold_data;

`ifdef DBUS_WB_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT);
  logic [15:0] wait_cnt;
  logic        timed_out;

  // Ack wins over the watchdog when both land in the same cycle.
  assign timed_out = (state == BUSY) && !flush_i && !wb_ack_i && (wait_cnt == TIMEOUT_VAL);
  assign bus_err_o = timed_out;
`endif

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    stallreq_o  = 1'b0;
    cpu_rdata_o = '0;
    bus_done    = 1'b0;
    hold_data   = wb_dat_i;
    case (state)
      IDLE: stallreq_o = cpu_ce_i & ~flush_i;
      BUSY: begin
        if (!flush_i) begin
          if (wb_ack_i) begin
            bus_done    = 1'b1;
            cpu_rdata_o = wb_we_o ? '0 : wb_dat_i;
          end
`ifdef DBUS_WB_TIMEOUT_EN
          else if (timed_out) begin
            bus_done    = 1'b1;
            hold_data   = DATA_W'(32'hDEADBEEF);
            cpu_rdata_o = hold_data;
          end
`endif
          else begin
            stallreq_o = 1'b1;
          end
        end
      end
      WAIT_STALL: cpu_rdata_o = rd_hold;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_sel_o <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      rd_hold  <= '0;
`ifdef DBUS_WB_TIMEOUT_EN
      wait_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= cpu_we_i;
            wb_sel_o <= cpu_sel_i;
            wb_adr_o <= cpu_addr_i;
            wb_dat_o <= cpu_wdata_i;
            state    <= BUSY;
`ifdef DBUS_WB_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (flush_i || bus_done) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
          end
          if (flush_i) begin
            state <= IDLE;
          end else if (bus_done) begin
            rd_hold <= hold_data;
            state   <= cpu_stall_i ? WAIT_STALL : IDLE;
          end
`ifdef DBUS_WB_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        WAIT_STALL: begin
          if (!cpu_stall_i || flush_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbus_wb_bridge.sv
// Directed bench for dbus_wb_bridge: reads, writes with wait states, stall hold,
// flush, async reset and (with DBUS_WB_TIMEOUT_EN) the bus watchdog.
module tb_dbus_wb_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_ce_i, cpu_we_i, cpu_stall_i, flush_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_addr_i, cpu_wdata_i;
  logic [31:0] cpu_rdata_o;
  logic        stallreq_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
`ifdef DBUS_WB_TIMEOUT_EN
  logic        bus_err_o;
`endif

  int total  = 0;
  int passed = 0;
  int stall_cnt;

  always #5 clk = ~clk;

`ifdef DBUS_WB_TIMEOUT_EN
  dbus_wb_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
`else
  dbus_wb_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
`endif
    .clk(clk), .rst(rst),
    .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_sel_i(cpu_sel_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_stall_i(cpu_stall_i), .flush_i(flush_i),
    .cpu_rdata_o(cpu_rdata_o), .stallreq_o(stallreq_o),
`ifdef DBUS_WB_TIMEOUT_EN
    .bus_err_o(bus_err_o),
`endif
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Inputs change on the falling edge; checks run 1 time unit later.
  task automatic drive(input logic ce, input logic we, input logic [31:0] addr,
                       input logic [3:0] sel, input logic [31:0] wdata,
                       input logic ack, input logic [31:0] rdata,
                       input logic stall, input logic flush);
    @(negedge clk);
    cpu_ce_i = ce; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel;
    cpu_wdata_i = wdata; wb_ack_i = ack; wb_dat_i = rdata;
    cpu_stall_i = stall; flush_i = flush;
    #1;
  endtask

  task automatic idle_in(input logic ack);
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, ack, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    cpu_ce_i = 0; cpu_we_i = 0; cpu_sel_i = 0; cpu_addr_i = 0; cpu_wdata_i = 0;
    cpu_stall_i = 0; flush_i = 0; wb_dat_i = 0; wb_ack_i = 0;

    // Reset state
    #12;
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_stallreq", stallreq_o, 0);
    check("rst_rdata", cpu_rdata_o, 0);
    @(negedge clk); rst = 1'b1;
    idle_in(1'b0);

    // Read of 0x100, acked on the first BUSY cycle
    drive(1, 0, 32'h0000_0100, 4'hF, 32'h0, 0, 32'h0, 0, 0);
    check("rd_req_stallreq", stallreq_o, 1);
    check("rd_req_cyc", wb_cyc_o, 0);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'h1234_5678, 0, 0);
    check("rd_busy_cyc", wb_cyc_o, 1);
    check("rd_busy_stb", wb_stb_o, 1);
    check("rd_busy_we", wb_we_o, 0);
    check("rd_busy_adr", wb_adr_o, 32'h0000_0100);
    check("rd_ack_stallreq", stallreq_o, 0);
    check("rd_ack_rdata", cpu_rdata_o, 32'h1234_5678);
    idle_in(1'b0);
    check("rd_done_cyc", wb_cyc_o, 0);
    check("rd_done_stb", wb_stb_o, 0);
    check("rd_done_rdata", cpu_rdata_o, 0);

    // Write 0xA5A5A5A5 to 0x200, sel 0011, three wait states
    stall_cnt = 0;
    drive(1, 1, 32'h0000_0200, 4'b0011, 32'hA5A5_A5A5, 0, 32'h0, 0, 0);
    if (stallreq_o) stall_cnt++;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 32'h0, 4'h0, 32'h0, (i == 3), 32'h5555_5555, 0, 0);
      if (stallreq_o) stall_cnt++;
      check("wr_busy_cyc", wb_cyc_o, 1);
      check("wr_busy_we", wb_we_o, 1);
      check("wr_busy_dat", wb_dat_o, 32'hA5A5_A5A5);
      check("wr_busy_sel", wb_sel_o, 4'b0011);
      check("wr_busy_adr", wb_adr_o, 32'h0000_0200);
    end
    check("wr_ack_rdata", cpu_rdata_o, 0);
    check("wr_stall_cycles", stall_cnt, 4);
    idle_in(1'b0);
    check("wr_done_cyc", wb_cyc_o, 0);
    check("wr_done_we", wb_we_o, 0);

    // Ack while in IDLE is ignored
    idle_in(1'b1);
    idle_in(1'b0);
    check("idle_ack_cyc", wb_cyc_o, 0);
    check("idle_ack_stallreq", stallreq_o, 0);

    // Read acked with 0xCAFE0001 while the pipeline is frozen
    drive(1, 0, 32'h0000_0300, 4'hF, 32'h0, 0, 32'h0, 1, 0);
    drive(1, 0, 32'h0000_0300, 4'hF, 32'h0, 1, 32'hCAFE_0001, 1, 0);
    check("st_ack_rdata", cpu_rdata_o, 32'hCAFE_0001);
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 32'h0000_0300, 4'hF, 32'h0, 0, 32'h0, (i < 2), 0);
      check("st_hold_rdata", cpu_rdata_o, 32'hCAFE_0001);
      check("st_hold_cyc", wb_cyc_o, 0);
      check("st_hold_stallreq", stallreq_o, 0);
    end
    idle_in(1'b0);
    check("st_idle_rdata", cpu_rdata_o, 0);
    check("st_idle_cyc", wb_cyc_o, 0);

    // Flush in the second BUSY cycle, then a late ack
    drive(1, 0, 32'h0000_0400, 4'hF, 32'h0, 0, 32'h0, 0, 0);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 0, 0);
    check("fl_busy1_stallreq", stallreq_o, 1);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 0, 32'h0, 0, 1);
    check("fl_busy2_cyc", wb_cyc_o, 1);
    check("fl_busy2_stallreq", stallreq_o, 0);
    drive(0, 0, 32'h0, 4'h0, 32'h0, 1, 32'hBAD0_BAD0, 0, 0);
    check("fl_after_cyc", wb_cyc_o, 0);
    check("fl_after_stb", wb_stb_o, 0);
    check("fl_late_ack_rdata", cpu_rdata_o, 0);
    check("fl_late_ack_stallreq", stallreq_o, 0);
    idle_in(1'b0);
    check("fl_idle_cyc", wb_cyc_o, 0);

    // Async reset pulse mid-BUSY
    drive(1, 1, 32'h0000_0500, 4'hF, 32'h1111_2222, 0, 32'h0, 0, 0);
    idle_in(1'b0);
    check("ar_busy_cyc", wb_cyc_o, 1);
    #1 rst = 1'b0;
    #1;
    check("ar_cyc_async", wb_cyc_o, 0);
    check("ar_stb_async", wb_stb_o, 0);
    @(negedge clk); rst = 1'b1;
    #1;
    check("ar_rel_cyc", wb_cyc_o, 0);
    check("ar_rel_we", wb_we_o, 0);
    check("ar_rel_adr", wb_adr_o, 0);
    check("ar_rel_dat", wb_dat_o, 0);
    check("ar_rel_sel", wb_sel_o, 0);
    check("ar_rel_stallreq", stallreq_o, 0);
    check("ar_rel_rdata", cpu_rdata_o, 0);

`ifdef DBUS_WB_TIMEOUT_EN
    // Slave never acks: watchdog fires after four waiting BUSY cycles
    drive(1, 0, 32'h0000_0600, 4'hF, 32'h0, 0, 32'h0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      idle_in(1'b0);
      check("to_wait_err", bus_err_o, 0);
      check("to_wait_stallreq", stallreq_o, 1);
    end
    idle_in(1'b0);
    check("to_err_pulse", bus_err_o, 1);
    check("to_err_rdata", cpu_rdata_o, 32'hDEAD_BEEF);
    check("to_err_stallreq", stallreq_o, 0);
    idle_in(1'b0);
    check("to_after_err", bus_err_o, 0);
    check("to_after_cyc", wb_cyc_o, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dbus_wb_bridge.md
Name: dbus_wb_bridge

Overview:
- Sits between the CPU core's data-RAM port (MEM stage) and a Wishbone B4 classic master bus.
- Converts the core's single-cycle ce/we/sel/addr/wdata request into a cyc/stb/ack transaction.
- Raises a stall request toward the stall controller until the bus acknowledges.
- Holds read data while the pipeline is frozen by other stall sources, and drops the transaction on pipeline flush.

Parameters:
ADDR_W, 32, address width of the CPU and bus ports
DATA_W, 32, data width; sel width is DATA_W/8
TIMEOUT, 255, bus-wait cycles before a forced error termination (used only with the optional feature)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset (0 = reset)
cpu_ce_i  in  1  MEM-stage memory access request
cpu_we_i  in  1  1 = write, 0 = read
cpu_sel_i  in  DATA_W/8  byte selects
cpu_addr_i  in  ADDR_W  byte address
cpu_wdata_i  in  DATA_W  store data
cpu_stall_i  in  1  MEM stage frozen by another stall source
flush_i  in  1  pipeline flush (exception)
cpu_rdata_o  out  DATA_W  load data to MEM stage
stallreq_o  out  1  stall request to stall controller
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  DATA_W/8  Wishbone byte selects
wb_adr_o  out  ADDR_W  Wishbone address
wb_dat_o  out  DATA_W  Wishbone write data
wb_dat_i  in  DATA_W  Wishbone read data
wb_ack_i  in  1  Wishbone acknowledge

Behaviour:
- Reset (rst=0, asynchronous):
  - State = IDLE.
  - All wb_* outputs = 0.
  - Read-hold buffer = 0.
  - stallreq_o = 0, cpu_rdata_o = 0.
- All wb_* outputs are registered. stallreq_o and cpu_rdata_o are combinational from state and inputs.
- IDLE:
  - stallreq_o = cpu_ce_i & ~flush_i; cpu_rdata_o = 0.
  - If cpu_ce_i & ~flush_i: next edge latches we/sel/addr/wdata onto wb_*, sets cyc = stb = 1, goes to BUSY.
  - Otherwise stays in IDLE.
- BUSY:
  - wb_* outputs are held stable until ack.
  - flush_i=1 has priority over everything. Next edge: cyc = stb = we = 0, go to IDLE. Any ack arriving in that cycle is discarded. stallreq_o = 0 in that cycle.
  - ack=0: stallreq_o = 1.
  - ack=1:
    - stallreq_o = 0 and cpu_rdata_o = wb_dat_i in the same cycle (0 for writes).
    - Next edge: cyc = stb = we = 0; read-hold buffer <= wb_dat_i.
    - Go to WAIT_STALL if cpu_stall_i=1, else to IDLE.
- WAIT_STALL:
  - stallreq_o = 0; cpu_rdata_o = read-hold buffer; no bus activity.
  - Returns to IDLE at the first edge with cpu_stall_i=0.
  - flush_i=1 also returns to IDLE.
- Latency:
  - Minimum 2 cycles per access: request cycle in IDLE, then ack in the first BUSY cycle.
  - The core stalls for 1 + (bus wait states) cycles.
- The bridge issues no back-to-back cycles: at least one IDLE cycle (cyc=0) separates consecutive transactions.
- wb_ack_i in IDLE or WAIT_STALL is ignored.
- cpu_ce_i changing while in BUSY is ignored; the latched request completes.
- Reset mid-transaction drops cyc/stb immediately (asynchronous).

Optional Feature:
Macro DBUS_WB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT, the transaction terminates as if acked, with read data forced to 32'hDEADBEEF.
  - An extra output bus_err_o (1 bit, reset 0) pulses high for that one cycle.
- Undefined: no counter, no bus_err_o port; BUSY waits indefinitely for ack.

Test Plan:
- Read of 0x0000_0100, slave acks on the first BUSY cycle with 0x1234_5678: stallreq_o high for 1 cycle, cpu_rdata_o=0x1234_5678 in the ack cycle, then cyc=0.
- Write of 0xA5A5_A5A5 to 0x0000_0200 with sel=4'b0011, ack after 3 wait states: wb_dat_o/wb_sel_o stable for 4 BUSY cycles, we=1, stallreq_o high for 4 cycles total.
- Read acked with 0xCAFE_0001 while cpu_stall_i=1 for 3 cycles: state WAIT_STALL, cpu_rdata_o holds 0xCAFE_0001 for all 3 cycles, no new cyc.
- flush_i asserted in the 2nd BUSY cycle: cyc/stb=0 at the next edge, stallreq_o=0, a late ack the following cycle is ignored, state IDLE.
- Async reset pulse mid-BUSY: wb_cyc_o falls without a clock edge, and all outputs are 0 after release.
- With DBUS_WB_TIMEOUT_EN and TIMEOUT=4, slave never acks: bus_err_o pulses after 4 BUSY cycles, and cpu_rdata_o=0xDEADBEEF in that cycle.
